// File: rtl/accum_rr_scheduler.sv
// accum_rr_scheduler: round-robin sequencer for the shared accumulator datapath.
// N_REQ requesters compete for one adder. The winner's operand is registered onto
// dp_data, add is pulsed, one settle cycle follows, and then the alarm is examined.
// Optional macro ALARM_AUTOCLR_EN: leave ALARM on its own after AUTOCLR_CYC cycles.
module accum_rr_scheduler #(
    parameter int N_REQ       = 2,
    parameter int DATA_W      = 8,
    parameter int AUTOCLR_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    input  logic                      clr_req,
    input  logic                      al,
    output logic [DATA_W-1:0]         dp_data,
    output logic                      add,
    output logic                      clr,
    output logic                      l,
    output logic                      busy,
    output logic [1:0]                state_dbg
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // ALARM gets its own code so it cannot be confused with WAIT internally
    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_GRANT = 3'd2,
        S_WAIT  = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    winner_q, winner_d;
    logic [DATA_W-1:0]   dp_data_q, dp_data_d;
    logic                clr_pend_q, clr_pend_d;

`ifdef ALARM_AUTOCLR_EN
    localparam int CNT_W = (AUTOCLR_CYC > 1) ? $clog2(AUTOCLR_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTOCLR_CYC - 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

    // Unpack the flat operand bus into one entry per requester
    logic [DATA_W-1:0]   data_arr [N_REQ];
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search: first set req bit starting just above the pointer, wrapping
    logic                found;
    logic [IDX_W-1:0]    pick;
    logic [IDX_W:0]      cand;
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i + 1);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    // State and datapath-side registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            ptr_q      <= IDX_W'(N_REQ - 1);
            winner_q   <= '0;
            dp_data_q  <= '0;
            clr_pend_q <= 1'b0;
`ifdef ALARM_AUTOCLR_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            winner_q   <= winner_d;
            dp_data_q  <= dp_data_d;
            clr_pend_q <= clr_pend_d;
`ifdef ALARM_AUTOCLR_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Next-state logic; winner and operand are captured on the IDLE->GRANT transition
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        winner_d   = winner_q;
        dp_data_d  = dp_data_q;
        clr_pend_d = clr_pend_q;
`ifdef ALARM_AUTOCLR_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_INIT: begin
                clr_pend_d = 1'b0;
                state_d    = S_IDLE;
            end
            S_IDLE: begin
                if (clr_req || clr_pend_q) begin
                    state_d = S_INIT;
                end else if (al) begin
                    state_d = S_ALARM;
`ifdef ALARM_AUTOCLR_EN
                    cnt_d   = '0;
`endif
                end else if (found) begin
                    state_d   = S_GRANT;
                    winner_d  = pick;
                    dp_data_d = data_arr[pick];
                end
            end
            S_GRANT: begin
                // A clear arriving mid-transaction waits until the add has settled
                ptr_d   = winner_q;
                state_d = S_WAIT;
                if (clr_req) clr_pend_d = 1'b1;
            end
            S_WAIT: begin
                state_d = S_IDLE;
                if (clr_req) clr_pend_d = 1'b1;
            end
            S_ALARM: begin
                if (clr_req) begin
                    state_d = S_INIT;
                end
`ifdef ALARM_AUTOCLR_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d = S_INIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_INIT;
        endcase
    end

    // Outputs decode purely from the current state, so they are exclusive by construction
    always_comb begin
        ack       = '0;
        add       = 1'b0;
        clr       = 1'b0;
        l         = 1'b0;
        busy      = (state_q != S_IDLE);
        state_dbg = (state_q == S_ALARM) ? 2'b11 : state_q[1:0];
        case (state_q)
            S_INIT:  clr = 1'b1;
            S_GRANT: begin
                add           = 1'b1;
                ack[winner_q] = 1'b1;
            end
            S_ALARM: l = 1'b1;
            default: ;
        endcase
    end

    assign dp_data = dp_data_q;

endmodule

// File: tb/tb_accum_rr_scheduler.sv
// Directed testbench for accum_rr_scheduler (N_REQ=2, DATA_W=8).
// Build with ALARM_AUTOCLR_EN defined to also exercise the ALARM auto-clear path.
module tb_accum_rr_scheduler;

`ifdef ALARM_AUTOCLR_EN
    localparam int AC = 4;
`else
    localparam int AC = 16;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [15:0] req_data;
    logic [1:0]  ack;
    logic        clr_req;
    logic        al;
    logic [7:0]  dp_data;
    logic        add;
    logic        clr;
    logic        l;
    logic        busy;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    accum_rr_scheduler #(.N_REQ(2), .DATA_W(8), .AUTOCLR_CYC(AC)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .clr_req(clr_req), .al(al), .dp_data(dp_data), .add(add), .clr(clr),
        .l(l), .busy(busy), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one clock; observe 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b00; req_data = 16'h0000; clr_req = 1'b0; al = 1'b0;
        step(); step();
        total++; if (clr !== 1'b1) begin bad++; $display("FAIL rst_clr got=%b exp=1", clr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", busy); end
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL rst_ack got=%b exp=00", ack); end
        total++; if ({add, l} !== 2'b00) begin bad++; $display("FAIL rst_add_l got=%b exp=00", {add, l}); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
        total++; if (dp_data !== 8'h00) begin bad++; $display("FAIL rst_dp_data got=%h exp=00", dp_data); end
        rst_n = 1'b1;
        #1;
        total++; if (clr !== 1'b1) begin bad++; $display("FAIL init_clr got=%b exp=1", clr); end
        step();
        total++; if (clr !== 1'b0) begin bad++; $display("FAIL idle_clr got=%b exp=0", clr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL idle_state got=%0d exp=1", state_dbg); end
        $display("reset: released, idle");
    endtask

    // both requesters held high: grants must alternate starting with req0
    task automatic test_round_robin();
        logic [1:0] exp_ack;
        logic [7:0] exp_dp;
        int g;
        g = 0;
        req_data = 16'hB2A1;
        req = 2'b11;
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_ack = 2'b00;
            exp_dp  = 8'h00;
            if (c % 3 == 1) begin
                exp_ack = (g % 2 == 0) ? 2'b01 : 2'b10;
                exp_dp  = (g % 2 == 0) ? 8'hA1 : 8'hB2;
            end
            total++; if (ack !== exp_ack) begin bad++; $display("FAIL rr_ack cyc=%0d got=%b exp=%b", c, ack, exp_ack); end
            total++; if (add !== (exp_ack != 2'b00)) begin bad++; $display("FAIL rr_add cyc=%0d got=%b exp=%b", c, add, exp_ack != 2'b00); end
            if (c % 3 == 1) begin
                total++; if (dp_data !== exp_dp) begin bad++; $display("FAIL rr_dp cyc=%0d got=%h exp=%h", c, dp_data, exp_dp); end
                $display("rr grant %0d: ack=%b dp_data=%h", g, ack, dp_data);
                g++;
            end
        end
        req = 2'b00;
    endtask

    task automatic test_single();
        req_data = 16'h0005;
        req = 2'b01;
        step();
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL single_ack got=%b exp=01", ack); end
        total++; if (add !== 1'b1) begin bad++; $display("FAIL single_add got=%b exp=1", add); end
        total++; if (dp_data !== 8'h05) begin bad++; $display("FAIL single_dp got=%h exp=05", dp_data); end
        total++; if (state_dbg !== 2'd2) begin bad++; $display("FAIL single_grant_state got=%0d exp=2", state_dbg); end
        req = 2'b00;
        step();
        total++; if (state_dbg !== 2'd3) begin bad++; $display("FAIL single_wait_state got=%0d exp=3", state_dbg); end
        total++; if ({ack, add} !== 3'b000) begin bad++; $display("FAIL single_wait_out got=%b exp=000", {ack, add}); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        total++; if (dp_data !== 8'h05) begin bad++; $display("FAIL single_dp_hold got=%h exp=05", dp_data); end
        $display("single: ack=01 dp_data=05");
    endtask

    task automatic test_alarm();
        req_data = 16'h0077;
        req = 2'b01;
        al  = 1'b1;
        step();
        al = 1'b0;
        total++; if (state_dbg !== 2'd3) begin bad++; $display("FAIL alarm_state got=%0d exp=3", state_dbg); end
        total++; if (l !== 1'b1) begin bad++; $display("FAIL alarm_l got=%b exp=1", l); end
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL alarm_ack got=%b exp=00", ack); end
        step();
        total++; if ({l, ack, add} !== 4'b1000) begin bad++; $display("FAIL alarm_hold got=%b exp=1000", {l, ack, add}); end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        total++; if (clr !== 1'b1) begin bad++; $display("FAIL alarm_clr got=%b exp=1", clr); end
        total++; if (l !== 1'b0) begin bad++; $display("FAIL alarm_l_off got=%b exp=0", l); end
        step();
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL alarm_idle got=%0d exp=1", state_dbg); end
        step();
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL alarm_after_ack got=%b exp=01", ack); end
        total++; if (dp_data !== 8'h77) begin bad++; $display("FAIL alarm_after_dp got=%h exp=77", dp_data); end
        req = 2'b00;
        step(); step();
        $display("alarm: cleared, req0 granted");
    endtask

    // clear request during a transaction is deferred until the add completes
    task automatic test_clr_pend();
        req_data = 16'h3300;
        req = 2'b10;
        step();
        clr_req = 1'b1;
        total++; if (ack !== 2'b10) begin bad++; $display("FAIL pend_ack got=%b exp=10", ack); end
        total++; if (add !== 1'b1) begin bad++; $display("FAIL pend_add got=%b exp=1", add); end
        total++; if (dp_data !== 8'h33) begin bad++; $display("FAIL pend_dp got=%h exp=33", dp_data); end
        req = 2'b00;
        step();
        clr_req = 1'b0;
        total++; if (state_dbg !== 2'd3) begin bad++; $display("FAIL pend_wait got=%0d exp=3", state_dbg); end
        step();
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL pend_idle got=%0d exp=1", state_dbg); end
        step();
        total++; if (clr !== 1'b1) begin bad++; $display("FAIL pend_clr got=%b exp=1", clr); end
        step();
        total++; if ({clr, busy} !== 2'b00) begin bad++; $display("FAIL pend_done got=%b exp=00", {clr, busy}); end
        $display("clr_pend: ack=10 then clear");
    endtask

    // reset mid-WAIT restores the pointer so req0 wins next
    task automatic test_reset_mid();
        req_data = 16'h2211;
        req = 2'b11;
        step();
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL mid_first_ack got=%b exp=01", ack); end
        step();
        rst_n = 1'b0;
        #1;
        total++; if (clr !== 1'b1) begin bad++; $display("FAIL mid_clr got=%b exp=1", clr); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL mid_state got=%0d exp=0", state_dbg); end
        total++; if (ack !== 2'b00) begin bad++; $display("FAIL mid_ack got=%b exp=00", ack); end
        step();
        rst_n = 1'b1;
        step();
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL mid_idle got=%0d exp=1", state_dbg); end
        step();
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL mid_ptr_ack got=%b exp=01", ack); end
        req = 2'b00;
        step(); step();
        $display("reset_mid: req0 wins after reset");
    endtask

`ifdef ALARM_AUTOCLR_EN
    task automatic test_autoclr();
        al = 1'b1;
        step();
        al = 1'b0;
        total++; if (l !== 1'b1) begin bad++; $display("FAIL auto_entry got=%b exp=1", l); end
        for (int c = 1; c <= 3; c++) begin
            step();
            total++; if (state_dbg !== 2'd3) begin bad++; $display("FAIL auto_dwell cyc=%0d got=%0d exp=3", c, state_dbg); end
        end
        step();
        total++; if (clr !== 1'b1) begin bad++; $display("FAIL auto_clr got=%b exp=1", clr); end
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL auto_idle got=%b exp=0", busy); end
        $display("autoclr: INIT after 4 cycles");
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_alarm();
        test_clr_pend();
        test_reset_mid();
`ifdef ALARM_AUTOCLR_EN
        test_autoclr();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
